// File: rtl/watch_pkg.sv
// Shared constants for the watch keypad/time-entry path: key codes, cursor
// positions, per-position digit limits and the entry FSM encoding.
package watch_pkg;

  localparam logic [3:0] KEY_NONE = 4'hF;

  localparam logic [2:0] POS_HT = 3'd0;
  localparam logic [2:0] POS_HO = 3'd1;
  localparam logic [2:0] POS_MT = 3'd2;
  localparam logic [2:0] POS_MO = 3'd3;
  localparam logic [2:0] POS_ST = 3'd4;
  localparam logic [2:0] POS_SO = 3'd5;

  localparam logic [3:0] HOUR_TEN_MAX      = 4'd2;
  localparam logic [3:0] HOUR_ONE_MAX      = 4'd9;
  localparam logic [3:0] HOUR_ONE_MAX_AT_2 = 4'd3;
  localparam logic [3:0] MIN_TEN_MAX       = 4'd5;
  localparam logic [3:0] MIN_ONE_MAX       = 4'd9;
  localparam logic [3:0] SEC_TEN_MAX       = 4'd5;
  localparam logic [3:0] SEC_ONE_MAX       = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_COMMIT
  } state_e;

  // Largest digit allowed at a cursor position; the hour-ones limit depends
  // on the hour-tens digit already in the buffer.
  function automatic logic [3:0] digit_max(input logic [2:0] pos, input logic [3:0] h_ten);
    logic [3:0] mx;
    mx = SEC_ONE_MAX;
    case (pos)
      POS_HT:  mx = HOUR_TEN_MAX;
      POS_HO:  mx = (h_ten == HOUR_TEN_MAX) ? HOUR_ONE_MAX_AT_2 : HOUR_ONE_MAX;
      POS_MT:  mx = MIN_TEN_MAX;
      POS_MO:  mx = MIN_ONE_MAX;
      POS_ST:  mx = SEC_TEN_MAX;
      default: mx = SEC_ONE_MAX;
    endcase
    return mx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// 10-key keypad debouncer: one press strobe per stable key code, re-armed
// only after the keypad has been idle for the same debounce time.
module key_debounce
  import watch_pkg::*;
#(
  parameter int DEBOUNCE = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad_i,
  output logic       press_o,
  output logic [3:0] code_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE);

  logic [3:0]    raw_code;
  logic [3:0]    n_low;
  logic [3:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          stable_done;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    raw_code = KEY_NONE;
    n_low    = '0;
    for (int k = 0; k < 10; k++) begin
      if (!keypad_i[k]) begin
        n_low    = n_low + 4'd1;
        raw_code = 4'(k);
      end
    end
    if (n_low != 4'd1) raw_code = KEY_NONE;
  end

  // cnt_q counts earlier consecutive samples equal to code_q, so this cycle
  // is the DEBOUNCE-th stable sample when the count sits at DEBOUNCE-1.
  assign stable_done = (raw_code == code_q) && (cnt_q == CNT_LAST);

  always_comb begin
    code_d  = code_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (raw_code != code_q) begin
      code_d = raw_code;
      cnt_d  = CW'(1);
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (stable_done) armed_d = (code_q == KEY_NONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= KEY_NONE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign press_o = armed_q && stable_done && (code_q != KEY_NONE);
  assign code_o  = code_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Set-mode time entry: collects six range-checked BCD digits from the keypad
// and hands them to the watch counter as a single-cycle load.
module time_set_ctrl
  import watch_pkg::*;
#(
  parameter int DEBOUNCE   = 20,
  parameter int TIMEOUT    = 10000,
  parameter int BLINK_HALF = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dip_sw,
  input  logic [9:0]  keypad,
  output logic        load,
  output logic [23:0] load_time,
  output logic        edit_active,
  output logic [2:0]  edit_pos,
  output logic        blink,
  output logic        reject
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  state_e          state_q;
  logic [5:0][3:0] digits_q, digits_nxt;
  logic [23:0]     load_time_q;
  logic [TW-1:0]   tmo_q;
  logic [BW-1:0]   blink_cnt_q;
  logic [2:0]      pos_q, slot;
  logic            load_q, reject_q, active_q, blink_q;
  logic            press, digit_ok;
  logic [3:0]      key_code;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_debounce (
    .clk      (clk),
    .rst      (rst),
    .keypad_i (keypad),
    .press_o  (press),
    .code_o   (key_code)
  );

  // Slot 5 of the digit buffer holds h_ten so the buffer packs straight into load_time.
  assign slot = POS_SO - pos_q;

  always_comb begin
    digits_nxt       = digits_q;
    digits_nxt[slot] = key_code;
    digit_ok         = (key_code <= digit_max(pos_q, digits_q[5]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      // NOTE: the digit buffer is reset explicitly so a partial entry can never reach a later load.
      digits_q    <= '0;
      load_time_q <= '0;
      tmo_q       <= '0;
      blink_cnt_q <= '0;
      pos_q       <= POS_HT;
      load_q      <= 1'b0;
      reject_q    <= 1'b0;
      active_q    <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; later assignments below override these pulse defaults.
      load_q   <= 1'b0;
      reject_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_COMMIT: begin
          if (dip_sw) begin
            state_q     <= ST_ENTRY;
            active_q    <= 1'b1;
            pos_q       <= POS_HT;
            digits_q    <= '0;
            tmo_q       <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ENTRY: begin
          if (!dip_sw || tmo_q == TMO_LAST) begin
            state_q     <= ST_IDLE;
            active_q    <= 1'b0;
            pos_q       <= POS_HT;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_q <= '0;
              blink_q     <= ~blink_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + BW'(1);
            end
            if (press) begin
              tmo_q <= '0;
              if (!digit_ok) begin
                reject_q <= 1'b1;
              end else begin
                digits_q    <= digits_nxt;
                blink_cnt_q <= '0;
                blink_q     <= 1'b0;
                if (pos_q == POS_SO) begin
                  state_q     <= ST_COMMIT;
                  active_q    <= 1'b0;
                  pos_q       <= POS_HT;
                  load_q      <= 1'b1;
                  load_time_q <= digits_nxt;
                end else begin
                  pos_q <= pos_q + 3'd1;
                end
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign load        = load_q;
  assign load_time   = load_time_q;
  assign edit_active = active_q;
  assign edit_pos    = pos_q;
  assign blink       = blink_q;
  assign reject      = reject_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus randomized key sessions,
// checked against a digit-level model of the entry rules.
module tb_time_set_ctrl;

  localparam int DEBOUNCE   = 20;
  localparam int TIMEOUT    = 10000;
  localparam int BLINK_HALF = 250;

  logic        clk = 1'b0;
  logic        rst;
  logic        dip_sw;
  logic [9:0]  keypad;
  logic        load;
  logic [23:0] load_time;
  logic        edit_active;
  logic [2:0]  edit_pos;
  logic        blink;
  logic        reject;

  time_set_ctrl #(
    .DEBOUNCE   (DEBOUNCE),
    .TIMEOUT    (TIMEOUT),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dip_sw      (dip_sw),
    .keypad      (keypad),
    .load        (load),
    .load_time   (load_time),
    .edit_active (edit_active),
    .edit_pos    (edit_pos),
    .blink       (blink),
    .reject      (reject)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int seen_loads = 0, seen_rejects = 0;
  int exp_loads = 0, exp_rejects = 0;
  int exp_evt_cyc = -1;
  int drop_cyc = -1;

  // Reference model: entry mode, cursor and the digits typed so far.
  bit          m_entry = 1'b0;
  int          m_pos = 0;
  int          m_dig[6];
  logic [23:0] exp_time = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always begin
    @(posedge clk);
    cyc++;
  end

  function automatic int m_max();
    case (m_pos)
      0:       return 2;
      1:       return (m_dig[0] == 2) ? 3 : 9;
      2, 4:    return 5;
      default: return 9;
    endcase
  endfunction

  function automatic int key_of(input logic [9:0] pat);
    int n, idx;
    n = 0;
    idx = -1;
    for (int i = 0; i < 10; i++) begin
      if (!pat[i]) begin
        n++;
        idx = i;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic logic [9:0] key(input int k);
    logic [9:0] one;
    one = 10'd1;
    return ~(one << k);
  endfunction

  task automatic clear_model();
    m_pos = 0;
    for (int i = 0; i < 6; i++) m_dig[i] = 0;
  endtask

  task automatic model_press(input int d);
    exp_evt_cyc = cyc + DEBOUNCE;
    if (d > m_max()) begin
      exp_rejects++;
    end else begin
      m_dig[m_pos] = d;
      m_pos++;
      if (m_pos == 6) begin
        exp_time = '0;
        for (int i = 0; i < 6; i++) exp_time = {exp_time[19:0], 4'(m_dig[i])};
        exp_loads++;
        clear_model();
      end
    end
  endtask

  // Holds a keypad pattern for 'hold' sampled cycles, then releases for 'rel'.
  task automatic press(input logic [9:0] pat, input int hold, input int rel);
    int d;
    d = key_of(pat);
    if (d >= 0 && hold >= DEBOUNCE && m_entry) model_press(d);
    keypad = pat;
    repeat (hold) @(posedge clk);
    #1 keypad = '1;
    repeat (rel) @(posedge clk);
    #1;
  endtask

  task automatic set_dip(input logic v);
    dip_sw = v;
    repeat (5) @(posedge clk);
    #1;
    m_entry = v;
    clear_model();
  endtask

  task automatic verify(input string tag);
    check({tag, "_loads"}, 32'(seen_loads), 32'(exp_loads));
    check({tag, "_rejects"}, 32'(seen_rejects), 32'(exp_rejects));
    check({tag, "_pos"}, 32'(edit_pos), 32'(m_pos));
    check({tag, "_active"}, 32'(edit_active), 32'(m_entry));
    check({tag, "_time"}, 32'(load_time), 32'(exp_time));
  endtask

  // Output monitor: pulse counting, event latency and blink timing.
  logic       prev_load = 1'b0, prev_reject = 1'b0, prev_active = 1'b0, prev_blink = 1'b0;
  logic [2:0] prev_pos = '0;
  int         blink_run = 0;

  always begin
    @(negedge clk);
    if (rst) begin
      prev_load = 1'b0; prev_reject = 1'b0; prev_active = 1'b0; prev_blink = 1'b0;
      prev_pos = '0; blink_run = 0;
    end else begin
      if (load) begin
        seen_loads++;
        check("load_latency", 32'(cyc), 32'(exp_evt_cyc));
        check("load_single", 32'(prev_load), 32'd0);
      end
      if (reject) begin
        seen_rejects++;
        check("reject_latency", 32'(cyc), 32'(exp_evt_cyc));
        check("reject_single", 32'(prev_reject), 32'd0);
      end
      if (!edit_active) begin
        check("idle_pos", 32'(edit_pos), 32'd0);
        check("idle_blink", 32'(blink), 32'd0);
        blink_run = 0;
      end else if (prev_active && edit_pos == prev_pos) begin
        blink_run++;
        if (blink !== prev_blink) begin
          check("blink_half", 32'(blink_run), 32'(BLINK_HALF));
          blink_run = 0;
        end
      end else begin
        check("blink_clear", 32'(blink), 32'd0);
        blink_run = 0;
      end
      if (prev_active && !edit_active) drop_cyc = cyc;
      prev_load = load; prev_reject = reject; prev_active = edit_active;
      prev_blink = blink; prev_pos = edit_pos;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         r, k, k2, last_press, rej_before;
    logic [9:0] pat;

    rst = 1'b1;
    dip_sw = 1'b0;
    keypad = '1;
    clear_model();
    #12;
    check("rst_load", 32'(load), 32'd0);
    check("rst_time", 32'(load_time), 32'd0);
    check("rst_active", 32'(edit_active), 32'd0);
    check("rst_pos", 32'(edit_pos), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    check("rst_reject", 32'(reject), 32'd0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    // Plain entry of 12:34:56
    set_dip(1'b1);
    check("t1_enter_active", 32'(edit_active), 32'd1);
    for (int i = 1; i <= 6; i++) press(key(i), 30, 30);
    verify("t1");
    check("t1_time_const", 32'(load_time), 32'h123456);
    check("t1_pos_zero", 32'(edit_pos), 32'd0);

    // Hour-ones limit when h_ten is 2
    press(key(2), 30, 30);
    press(key(4), 30, 30);
    check("t2_pos_after_reject", 32'(edit_pos), 32'd1);
    press(key(3), 30, 30);
    press(key(5), 30, 30);
    press(key(9), 30, 30);
    press(key(5), 30, 30);
    press(key(9), 30, 30);
    verify("t2");
    check("t2_time_const", 32'(load_time), 32'h235959);

    // Bounce shorter than the debounce time, then a long hold and the boundary
    for (int i = 0; i < 10; i++) press(key(7), 5, (i == 9) ? 30 : 5);
    verify("t3_bounce");
    rej_before = seen_rejects;
    press(key(7), 200, 30);
    check("t3_one_press", 32'(seen_rejects - rej_before), 32'd1);
    press(key(1), DEBOUNCE - 1, 30);
    check("t3_short_hold", 32'(edit_pos), 32'd0);
    press(key(1), DEBOUNCE, 30);
    check("t3_exact_hold", 32'(edit_pos), 32'd1);
    verify("t3");

    // Multi-key, out-of-range first digit, zero accepted
    set_dip(1'b0);
    set_dip(1'b1);
    press(key(3) & key(4), 60, 30);
    verify("t4_multi");
    press(key(9), 30, 30);
    press(key(0), 30, 30);
    verify("t4");

    // Leaving set mode mid-entry
    set_dip(1'b0);
    set_dip(1'b1);
    press(key(1), 30, 30);
    press(key(2), 30, 30);
    press(key(3), 30, 30);
    set_dip(1'b0);
    verify("t5_off");
    set_dip(1'b1);
    verify("t5_on");

    // Inactivity timeout
    set_dip(1'b0);
    set_dip(1'b1);
    press(key(1), 30, 30);
    press(key(5), 30, 30);
    last_press = exp_evt_cyc;
    repeat (TIMEOUT - 200) @(posedge clk);
    #1;
    check("t6_before_timeout", 32'(edit_active), 32'd1);
    check("t6_pos_before", 32'(edit_pos), 32'd2);
    repeat (400) @(posedge clk);
    #1;
    check("t6_abort_cycle", 32'(drop_cyc), 32'(last_press + TIMEOUT));
    clear_model();
    verify("t6");

    // Randomized sessions
    for (int it = 0; it < 120; it++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        set_dip(~dip_sw);
      end else if (r == 1) begin
        press(key(int'($urandom_range(0, 9))), int'($urandom_range(1, DEBOUNCE - 3)),
              int'($urandom_range(DEBOUNCE + 2, 40)));
      end else if (r == 2) begin
        k  = int'($urandom_range(0, 8));
        k2 = int'($urandom_range(k + 1, 9));
        pat = key(k) & key(k2);
        press(pat, int'($urandom_range(DEBOUNCE + 2, 60)), int'($urandom_range(DEBOUNCE + 2, 50)));
      end else begin
        if (m_entry && $urandom_range(0, 9) < 7) k = int'($urandom_range(0, m_max()));
        else k = int'($urandom_range(0, 9));
        press(key(k), int'($urandom_range(DEBOUNCE + 2, 60)), int'($urandom_range(DEBOUNCE + 2, 50)));
      end
      verify("rand");
    end

    // Asynchronous reset in the middle of an entry
    set_dip(1'b0);
    set_dip(1'b1);
    press(key(1), 30, 30);
    press(key(5), 30, 30);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_load", 32'(load), 32'd0);
    check("arst_time", 32'(load_time), 32'd0);
    check("arst_active", 32'(edit_active), 32'd0);
    check("arst_pos", 32'(edit_pos), 32'd0);
    check("arst_blink", 32'(blink), 32'd0);
    check("arst_reject", 32'(reject), 32'd0);
    #3 rst = 1'b0;
    exp_time = '0;
    clear_model();
    repeat (30) @(posedge clk);
    #1;
    verify("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Sequences six-digit time entry from the 10-key keypad into the watch counter datapath while the set-mode DIP switch is on. Debounces and edge-qualifies key presses, range-checks each digit against its position (HH 00-23, MM/SS 00-59), and tracks the cursor. On the sixth valid digit it issues a single-cycle load command carrying the packed BCD time. The watch counter consumes only load/load_time; the display uses edit_active/edit_pos/blink to flash the digit being edited.

Parameters:
DEBOUNCE, 20, cycles (1 kHz clk = ms) a key code must be stable before acceptance; also the release re-arm time
TIMEOUT, 10000, cycles without an accepted key before entry aborts
BLINK_HALF, 250, cycles per blink half-period

Ports:
clk  in  1  1 kHz system clock
rst  in  1  reset; asynchronous, active-high
dip_sw  in  1  1 = set mode, 0 = run mode
keypad  in  10  active-low keys 0-9; keypad[k]=0 means key k pressed
load  out  1  one-cycle pulse: watch counter loads load_time
load_time  out  24  {h_ten,h_one,m_ten,m_one,s_ten,s_one}, 4-bit BCD each, MSB = h_ten
edit_active  out  1  1 while in ENTRY
edit_pos  out  3  cursor 0..5 (0 = h_ten); 0 outside ENTRY
blink  out  1  toggles every BLINK_HALF cycles in ENTRY; 0 otherwise
reject  out  1  one-cycle pulse on an accepted key whose digit is out of range

Behaviour:
- Reset (async): state IDLE; load=0, load_time=0, edit_active=0, edit_pos=0, blink=0, reject=0; debounce counters, timeout counter and digit buffer cleared; debouncer disarmed.
- Key code: valid only when exactly one keypad bit is 0 (value = its index). All-ones or multiple zeros = NONE.
- Press acceptance: a valid code held unchanged for DEBOUNCE consecutive cycles produces one press strobe, in the cycle the count completes. The debouncer is then disarmed until NONE has been seen for DEBOUNCE consecutive cycles. A code change restarts the count. Holding a key never repeats.
- FSM states IDLE, ENTRY, COMMIT.
- IDLE: dip_sw=1 -> ENTRY, edit_pos=0, buffer cleared, timeout cleared. Presses are ignored.
- ENTRY: on a press with digit d at position p, limits are: p0 <=2; p1 <=9, or <=3 if buffer h_ten==2; p2 <=5; p3 <=9; p4 <=5; p5 <=9.
  - Valid digit: store d, increment edit_pos, clear timeout. If p==5, go to COMMIT.
  - Invalid digit: reject=1 for one cycle, buffer and edit_pos unchanged, timeout cleared.
- ENTRY abort: dip_sw=0 or timeout reaching TIMEOUT -> IDLE with no load. Abort takes priority over a press in the same cycle.
- COMMIT: lasts one cycle. load=1, load_time=buffer. Next state is ENTRY at pos 0 if dip_sw=1, else IDLE. load_time holds its value after the pulse until the next COMMIT.
- Latency: accepted p5 press -> load asserted exactly 1 cycle later.
- Later change to position 0: if h_ten ends up 2 after h_one was already entered and h_one > 3, h_one is unreachable in that case because entry is strictly sequential. No retro-check is required.
- blink: cleared on ENTRY entry and on every cursor move, then toggles every BLINK_HALF cycles.
- Mid-operation reset: immediately returns to the reset state. No load is issued for a partial entry.

Decomposition:
- Shared package watch_pkg:
  - KEY_NONE code (4'hF)
  - position constants POS_HT..POS_SO
  - per-position max-digit constants, with HOUR_ONE_MAX_AT_2 = 3
  - FSM state encoding
- One sub-module key_debounce (keypad -> press strobe + 4-bit code, parameter DEBOUNCE), reusable by other keypad consumers.

Test Plan:
1. dip_sw=1; press 1,2,3,4,5,6 (each held 30, released 30 cycles) -> after the last press exactly one load with load_time=24'h123456, edit_pos back to 0.
2. Enter 2 then 4 -> reject pulse, edit_pos stays 1; then 3,5,9,5,9 -> load_time=24'h235959.
3. Key 7 held 5 cycles, released, re-pressed repeatedly (bounce < DEBOUNCE) -> no press accepted, edit_pos unchanged. Held 200 cycles -> exactly one accepted press.
4. Two keys low at once -> no press. Key 9 at position 0 -> reject. Key 0 -> accepted.
5. Enter 3 digits, then dip_sw=0 -> IDLE, edit_active=0, no load. Re-enable -> edit_pos=0.
6. Enter 2 digits, idle TIMEOUT cycles -> abort, no load. rst asserted mid-entry -> all outputs 0 asynchronously.
